// File: rtl/mem_loader_if.sv
// mem_loader_if: stream input, RAM write/read port and load status bundle for mem_loader.
interface mem_loader_if #(parameter int ADDR_W = 7, parameter int DATA_W = 16);
  logic              start;
  logic [ADDR_W:0]   len;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;
  logic              busy;
  logic              done;
  logic              err;
  logic              cpu_hold;
  modport master (
    input  start, len, in_valid, in_data, mem_dout,
    output in_ready, mem_wr, mem_addr, mem_din, busy, done, err, cpu_hold
  );
  modport slave (
    output start, len, in_valid, in_data, mem_dout,
    input  in_ready, mem_wr, mem_addr, mem_din, busy, done, err, cpu_hold
  );
endinterface

// File: rtl/mem_loader.sv
// mem_loader: streams words into the processor RAM, reads them back and releases the CPU only on a checksum match.
module mem_loader #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 128
) (
  input logic clk,
  input logic reset,
  mem_loader_if.master bus
);
  typedef enum logic [2:0] {IDLE, LOAD, VFY, CHK, DONE} state_t;
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);
  state_t state_q, state_d;
  logic [ADDR_W:0] n_q, n_d, wcnt_q, wcnt_d, n_clamp;
  logic [DATA_W-1:0] wsum_q, wsum_d, rsum_q, rsum_d, mem_din_q, mem_din_d, rsum_fin;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic mem_wr_q, mem_wr_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic cpu_hold_q, cpu_hold_d, rv_q, rv_d, hs;
  assign bus.in_ready = state_q == LOAD && wcnt_q < n_q;
  assign bus.mem_wr   = mem_wr_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_din  = mem_din_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.cpu_hold = cpu_hold_q;
  always_comb begin
    hs = bus.in_ready && bus.in_valid;
    n_clamp = bus.len > DEPTH_W ? DEPTH_W : bus.len;
    rsum_fin = rsum_q + bus.mem_dout;
    state_d = state_q;
    n_d = n_q;
    wcnt_d = wcnt_q;
    wsum_d = wsum_q;
    rsum_d = rsum_q;
    rv_d = rv_q;
    mem_wr_d = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_din_d = mem_din_q;
    busy_d = busy_q;
    done_d = done_q;
    err_d = err_q;
    cpu_hold_d = cpu_hold_q;
    case (state_q)
      IDLE, DONE: if (bus.start) begin
        n_d = n_clamp;
        wcnt_d = '0;
        wsum_d = '0;
        rsum_d = '0;
        rv_d = 1'b0;
        mem_addr_d = '0;
        err_d = 1'b0;
        state_d = n_clamp == '0 ? DONE : LOAD;
        busy_d = n_clamp != '0;
        done_d = n_clamp == '0;
        cpu_hold_d = n_clamp != '0;
      end
      LOAD: if (hs) begin
        mem_wr_d = 1'b1;
        mem_addr_d = wcnt_q[ADDR_W-1:0];
        mem_din_d = bus.in_data;
        wcnt_d = wcnt_q + 1'b1;
        wsum_d = wsum_q + bus.in_data;
      end else if (wcnt_q == n_q) begin
        state_d = VFY;
        mem_addr_d = '0;
        rv_d = 1'b0;
      end
      // read data lags the presented address by one cycle, so the first VFY cycle adds nothing
      VFY: begin
        rsum_d = rv_q ? rsum_fin : rsum_q;
        rv_d = 1'b1;
        state_d = {1'b0, mem_addr_q} == n_q - 1'b1 ? CHK : VFY;
        mem_addr_d = {1'b0, mem_addr_q} == n_q - 1'b1 ? mem_addr_q : mem_addr_q + 1'b1;
      end
      CHK: begin
        rsum_d = rsum_fin;
        state_d = DONE;
        mem_addr_d = '0;
        busy_d = 1'b0;
        done_d = 1'b1;
        err_d = rsum_fin != wsum_q;
        cpu_hold_d = rsum_fin != wsum_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      n_q <= '0;
      wcnt_q <= '0;
      wsum_q <= '0;
      rsum_q <= '0;
      rv_q <= 1'b0;
      mem_wr_q <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      cpu_hold_q <= 1'b1;
    end else begin
      state_q <= state_d;
      n_q <= n_d;
      wcnt_q <= wcnt_d;
      wsum_q <= wsum_d;
      rsum_q <= rsum_d;
      rv_q <= rv_d;
      mem_wr_q <= mem_wr_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q <= mem_din_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
      cpu_hold_q <= cpu_hold_d;
    end
  end
endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: scoreboard bench; accepted words queue expected writes that the monitor checks against the RAM port.
module tb_mem_loader;
  logic clk = 1'b0, reset = 1'b0;
  always #5 clk = ~clk;
  mem_loader_if bus ();
  mem_loader dut (.clk(clk), .reset(reset), .bus(bus));
  typedef struct {int cyc; logic [6:0] addr; logic [15:0] data;} wr_t;
  wr_t sb[$];
  wr_t e;
  logic [15:0] ram [128];
  logic [15:0] words [256];
  logic [6:0] exp_addr = '0, last_addr = '0;
  int cyc = 0, n_wr = 0, n_chk = 0, n_fail = 0;
  bit corrupt = 1'b0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mem_wr) ram[bus.mem_addr] <= bus.mem_din;
    bus.mem_dout <= ram[bus.mem_addr] ^ ((corrupt && bus.mem_addr == 7'd1) ? 16'h0001 : 16'h0000);
  end
  always @(negedge clk) begin
    if (reset && bus.start && !bus.busy) begin
      exp_addr = '0;
      n_wr = 0;
    end
    if (bus.mem_wr === 1'b1) begin
      if (sb.size() == 0) chk("wr_spurious", sb.size(), 1);
      else begin
        e = sb.pop_front();
        chk("wr_addr", bus.mem_addr, e.addr);
        chk("wr_data", bus.mem_din, e.data);
        chk("wr_cycle", cyc, e.cyc);
      end
      n_wr++;
      last_addr = bus.mem_addr;
    end
    if (reset && bus.in_valid && bus.in_ready) begin
      sb.push_back('{cyc + 1, exp_addr, bus.in_data});
      exp_addr++;
    end
  end
  task automatic run_load(input int len, input bit stall, input int nwords, input int abort,
                          input int exp_wr, input bit exp_err);
    int i = 0;
    int t;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.len = len[7:0];
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (t = 0; t < 1000 && !bus.done && !(abort > 0 && i >= abort); t++) begin
      bus.in_valid = (i < nwords) && (!stall || t % 2 == 0);
      bus.in_data = words[i];
      @(negedge clk);
      if (bus.in_valid) chk("in_ready", bus.in_ready, i < exp_wr);
      if (bus.in_valid && bus.in_ready) i++;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    if (abort == 0) begin
      chk("load_timeout", t < 1000, 1);
      if (len == 0) chk("len0_latency", t <= 2, 1);
      @(negedge clk);
      chk("write_count", n_wr, exp_wr);
      chk("sb_empty", sb.size(), 0);
      chk("status", {bus.busy, bus.done, bus.err, bus.cpu_hold}, {1'b0, 1'b1, exp_err, exp_err});
    end
  endtask
  initial begin
    bus.start = 1'b1;
    bus.len = 8'd4;
    bus.in_valid = 1'b1;
    bus.in_data = 16'hAAAA;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_outs", {bus.in_ready, bus.mem_wr, bus.mem_addr, bus.mem_din, bus.busy, bus.done,
                         bus.err, bus.cpu_hold}, 32'h1);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", {bus.busy, bus.done, bus.in_ready, bus.cpu_hold}, 4'b0001);
    words[0] = 16'h8040; words[1] = 16'h0019; words[2] = 16'h8080; words[3] = 16'h0010;
    run_load(4, 1'b0, 4, 0, 4, 1'b0);
    run_load(3, 1'b1, 10, 0, 3, 1'b0);
    corrupt = 1'b1;
    run_load(2, 1'b0, 2, 0, 2, 1'b1);
    corrupt = 1'b0;
    run_load(2, 1'b0, 2, 0, 2, 1'b0);
    run_load(0, 1'b0, 0, 0, 0, 1'b0);
    for (int i = 0; i < 256; i++) words[i] = 16'($urandom);
    run_load(200, 1'b0, 200, 0, 128, 1'b0);
    chk("last_addr", last_addr, 127);
    run_load(10, 1'b0, 10, 5, 10, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_outs", {bus.busy, bus.done, bus.mem_wr, bus.cpu_hold, bus.in_ready}, 5'b00010);
    chk("abort_sb", sb.size(), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    words[0] = 16'h1234; words[1] = 16'hF00D;
    run_load(2, 1'b0, 2, 0, 2, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
